// File: rtl/morse_pkg.sv
// morse_pkg
// Shared definitions for the Morse trainer input checker:
//   - per-letter target patterns and lengths (1 = dash, first symbol in
//     the MSB of the used field)
//   - letter FSM state encoding
//   - select_target(): maps the level FSM's one-hot letter selects to a
//     target pattern, priority C > E > F > H
package morse_pkg;

    localparam logic [3:0] PAT_C = 4'b1010;
    localparam logic [2:0] LEN_C = 3'd4;
    localparam logic [3:0] PAT_E = 4'b0000;
    localparam logic [2:0] LEN_E = 3'd1;
    localparam logic [3:0] PAT_F = 4'b0010;
    localparam logic [2:0] LEN_F = 3'd4;
    localparam logic [3:0] PAT_H = 4'b0000;
    localparam logic [2:0] LEN_H = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS,
        ST_GAP,
        ST_CHECK,
        ST_CLEAR,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] pattern;
        logic [2:0] len;
    } target_t;

    function automatic target_t select_target(input logic c, input logic e,
                                              input logic f, input logic h);
        target_t t;
        t = '{valid: 1'b0, pattern: 4'b0000, len: 3'd0};
        if (c)      t = '{valid: 1'b1, pattern: PAT_C, len: LEN_C};
        else if (e) t = '{valid: 1'b1, pattern: PAT_E, len: LEN_E};
        else if (f) t = '{valid: 1'b1, pattern: PAT_F, len: LEN_F};
        else if (h) t = '{valid: 1'b1, pattern: PAT_H, len: LEN_H};
        return t;
    endfunction

endpackage

// File: rtl/morse_symbol_timer.sv
// morse_symbol_timer
// Synchronizes the Morse key and times presses, releases and the clear
// interval with a single saturating duration counter.
// Ports:
//   clk, resetn       - clock, synchronous active-low reset
//   key               - raw (debounced, asynchronous) key
//   in_press/in_gap/in_clear - letter FSM is in PRESS / GAP / CLEAR
//   cnt_clr           - restart the counter (FSM changes state)
//   ks_rise           - synchronized key rising edge (only once armed)
//   sym_valid         - key released while in PRESS
//   sym_dash          - current press is long enough to be a dash
//   gap_done          - release has lasted GAP_CYC cycles
//   clear_done        - clear interval has lasted CLEAR_CYC cycles
import morse_pkg::*;

module morse_symbol_timer #(
    parameter int unsigned DOT_MAX_CYC = 12_500_000,
    parameter int unsigned GAP_CYC     = 25_000_000,
    parameter int unsigned CLEAR_CYC   = 50_000_000,
    parameter int unsigned CNT_W       = 27
) (
    input  logic clk,
    input  logic resetn,
    input  logic key,
    input  logic in_press,
    input  logic in_gap,
    input  logic in_clear,
    input  logic cnt_clr,
    output logic ks_rise,
    output logic sym_valid,
    output logic sym_dash,
    output logic gap_done,
    output logic clear_done
);

    logic             sync1;
    logic             ks;
    logic             ks_d;
    logic             primed;
    logic             armed;
    logic [CNT_W-1:0] cnt;

    // A key already held when reset is released must not look like a
    // press. 'primed' marks that sync1 holds a real key sample rather than
    // its reset value; rises only count after a real low has been seen.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1  <= 1'b0;
            ks     <= 1'b0;
            ks_d   <= 1'b0;
            primed <= 1'b0;
            armed  <= 1'b0;
        end else begin
            sync1  <= key;
            ks     <= sync1;
            ks_d   <= ks;
            primed <= 1'b1;
            if (primed && !sync1)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || cnt_clr || !(in_press || in_gap || in_clear))
            cnt <= '0;
        else if (cnt != '1)
            cnt <= cnt + 1'b1;
    end

    assign ks_rise    = armed & ks & ~ks_d;
    assign sym_valid  = in_press & ks_d & ~ks;
    assign sym_dash   = (cnt >= CNT_W'(DOT_MAX_CYC));
    assign gap_done   = in_gap & (cnt == CNT_W'(GAP_CYC - 1));
    assign clear_done = in_clear & (cnt == CNT_W'(CLEAR_CYC - 1));

endmodule

// File: rtl/morse_input_checker.sv
// morse_input_checker
// Collects up to four dot/dash symbols into a letter, compares it with the
// target chosen by the level FSM and pulses move_on (match) or error.
// While the level FSM clears the screen it times the clear interval and
// pulses move_on once.
// Ports:
//   clk, resetn            - clock, synchronous active-low reset
//   key                    - debounced Morse key, asynchronous
//   c_sig/e_sig/f_sig/h_sig - target letter selects (priority C>E>F>H)
//   enable_clear           - level FSM is in its clear/wait state
//   move_on, error         - registered one-cycle pulses
//   sym_bits, sym_count    - captured symbols (1 = dash) and their count
//
// state | meaning
// IDLE  | waiting for a press (needs a target) or a clear request
// PRESS | key held, timing press length
// GAP   | key released, waiting for next press or end of letter
// CHECK | compare letter with target, pulse result, flush buffer
// CLEAR | timing clear interval, key ignored
// DONE  | clear pulse sent, wait for enable_clear to drop
import morse_pkg::*;

module morse_input_checker #(
    parameter int unsigned DOT_MAX_CYC = 12_500_000,
    parameter int unsigned GAP_CYC     = 25_000_000,
    parameter int unsigned CLEAR_CYC   = 50_000_000,
    parameter int unsigned CNT_W       = 27
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       key,
    input  logic       c_sig,
    input  logic       e_sig,
    input  logic       f_sig,
    input  logic       h_sig,
    input  logic       enable_clear,
    output logic       move_on,
    output logic       error,
    output logic [3:0] sym_bits,
    output logic [2:0] sym_count
);

    state_t     state_q, state_d;
    logic [3:0] bits_q, bits_d;
    logic [2:0] count_q, count_d;
    logic       move_on_q, move_on_d;
    logic       error_q, error_d;
    target_t    tgt;

    logic ks_rise, sym_valid, sym_dash, gap_done, clear_done;

    assign tgt = select_target(c_sig, e_sig, f_sig, h_sig);

    morse_symbol_timer #(
        .DOT_MAX_CYC (DOT_MAX_CYC),
        .GAP_CYC     (GAP_CYC),
        .CLEAR_CYC   (CLEAR_CYC),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .key        (key),
        .in_press   (state_q == ST_PRESS),
        .in_gap     (state_q == ST_GAP),
        .in_clear   (state_q == ST_CLEAR),
        .cnt_clr    (state_d != state_q),
        .ks_rise    (ks_rise),
        .sym_valid  (sym_valid),
        .sym_dash   (sym_dash),
        .gap_done   (gap_done),
        .clear_done (clear_done)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            bits_q    <= 4'b0000;
            count_q   <= 3'd0;
            move_on_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bits_q    <= bits_d;
            count_q   <= count_d;
            move_on_q <= move_on_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bits_d    = bits_q;
        count_d   = count_q;
        move_on_d = 1'b0;
        error_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_clear)
                    state_d = ST_CLEAR;
                else if (ks_rise && tgt.valid)
                    state_d = ST_PRESS;
            end
            ST_PRESS: begin
                // A clear request abandons the letter silently.
                if (enable_clear) begin
                    bits_d  = 4'b0000;
                    count_d = 3'd0;
                    state_d = ST_CLEAR;
                end else if (sym_valid) begin
                    if (count_q == 3'd4) begin
                        error_d = 1'b1;
                        bits_d  = 4'b0000;
                        count_d = 3'd0;
                        state_d = ST_IDLE;
                    end else begin
                        bits_d  = {bits_q[2:0], sym_dash};
                        count_d = count_q + 3'd1;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (enable_clear) begin
                    bits_d  = 4'b0000;
                    count_d = 3'd0;
                    state_d = ST_CLEAR;
                end else if (ks_rise) begin
                    state_d = ST_PRESS;
                end else if (gap_done) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // Target is sampled here so late select changes are honoured.
                if (count_q == tgt.len && bits_q == tgt.pattern)
                    move_on_d = 1'b1;
                else
                    error_d = 1'b1;
                bits_d  = 4'b0000;
                count_d = 3'd0;
                state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                if (!enable_clear) begin
                    state_d = ST_IDLE;
                end else if (clear_done) begin
                    move_on_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!enable_clear)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign move_on   = move_on_q;
    assign error     = error_q;
    assign sym_bits  = bits_q;
    assign sym_count = count_q;

endmodule
